sequence_player: RTL
====================

// Module: sequence_player
// PURPOSE
//  Plays the memory-game pattern on the LEDs, paced by the toggling slow clock from the clock divider.
//  Sits directly downstream of the divider: its clk_out drives slow_clk here, sampled in the clock domain.
//  Each pattern element is one LED lit for one slow_clk period, then all LEDs dark for one period.
//  Elements come from an LFSR, so the input checker regenerates the same pattern from the same seed.
// PARAMETERS
//  LFSR_W    8   LFSR width; polynomial x^8+x^6+x^5+x^4+1 (fixed for the default width)
//  LEN_W     4   width of level; pattern length = level+1 (1..16)
//  NUM_LED   4   LED count; one-hot from a 2-bit symbol
// PORTS
//  clock     in   1       system clock
//  reset     in   1       synchronous, active-high
//  slow_clk  in   1       divider output; rising edges pace playback
//  start     in   1       begin playback (honoured in IDLE only)
//  replay    in   1       replay last pattern (only with SEQ_PLAYER_REPLAY_EN)
//  seed      in   LFSR_W  LFSR seed, captured on start
//  level     in   LEN_W   pattern length minus 1, captured on start
//  led       out  NUM_LED one-hot pattern LED, 0 when dark
//  busy      out  1       high from start acceptance until DONE
//  done      out  1       one-cycle pulse when playback completes
//  index     out  LEN_W   position of the current element (0-based)
// BEHAVIOUR
//  Reset: state=IDLE; led=0; busy=0; done=0; index=0; lfsr=8'h01; slow_prev=0; saved seed/len=0.
//  tick = slow_clk & ~slow_prev; slow_prev registered every cycle. No other use of slow_clk.
//  LFSR step: fb = q[7]^q[5]^q[4]^q[3]; q <= {q[6:0],fb}. symbol = q[1:0]; led = 1<<symbol.
//  Seed 0 is replaced by 8'h01 at capture, so the LFSR never locks up.
//  States:
//   IDLE: busy=0, led=0. start=1 -> capture seed/level, index=0, busy=1 next cycle -> ARM.
//         A tick in the same cycle as start is ignored.
//   ARM : wait for tick -> SHOW. This aligns the first element to a slow_clk edge.
//   SHOW: led = onehot(symbol). Hold until tick -> GAP.
//   GAP : led=0. On tick:
//         if index==len: done=1 for that cycle, busy=0 -> IDLE.
//         otherwise: step LFSR, index+1 -> SHOW.
//  Each SHOW and each GAP lasts one full slow_clk period, i.e. rising edge to rising edge.
//  Latency: the first element lights on the cycle after the first tick following start.
//  start while busy: ignored, no effect on state, index or LFSR.
//  index never wraps: len <= 15, and index stops at len.
//  Reset mid-playback: immediate return to IDLE with the reset values above. No done pulse.
//  slow_clk held constant (divider in reset): the block stalls in its current state indefinitely.
// CONFIGURATION
//  SEQ_PLAYER_REPLAY_EN defined:
//   - replay=1 in IDLE restarts from the saved seed and length; output is identical to the last run.
//   - start has priority if start and replay are both high.
//   - replay before any start plays seed 8'h01, length 1.
//  SEQ_PLAYER_REPLAY_EN undefined:
//   - replay is ignored; no saved-seed/length registers are built. The port stays present.
// TESTING
//  1 seed=8'h01, level=2, start, ticks every 8 cycles -> led 0010,0000,0100,0000,0001,0000;
//    done pulses once on the 7th tick; busy drops in the same cycle.
//  2 seed=8'h00, level=0 -> behaves as seed 8'h01: single element led=0010, then done.
//  3 start pulses during SHOW/GAP of test 1 -> sequence and index unchanged vs test 1.
//  4 start and tick in the same IDLE cycle -> first led lights only after the next tick.
//  5 reset asserted during the 2nd SHOW -> next cycle led=0, busy=0, index=0, no done pulse;
//    a fresh start with seed=8'h01 replays test 1 exactly.
//  6 (REPLAY_EN) after test 1, replay=1 -> identical led trace. Without the macro -> no response.

Source files
------------

// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - LFSR-driven LED pattern player paced by rising edges of slow_clk.
// Optional replay of the last pattern is built when SEQ_PLAYER_REPLAY_EN is defined.
module sequence_player #(
    parameter int LFSR_W  = 8,
    parameter int LEN_W   = 4,
    parameter int NUM_LED = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               slow_clk,
    input  logic               start,
    input  logic               replay,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [LEN_W-1:0]   level,
    output logic [NUM_LED-1:0] led,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   index
);

    typedef enum logic [1:0] {IDLE, ARM, SHOW, GAP} state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    index_q, index_d;
    logic [NUM_LED-1:0]  led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                slow_prev_q, slow_prev_d;
    logic                tick;
    logic                fb;
    logic [LFSR_W-1:0]   seed_fixed;

`ifdef SEQ_PLAYER_REPLAY_EN
    logic [LFSR_W-1:0]   saved_seed_q, saved_seed_d;
`else
    logic                unused_replay;
    assign unused_replay = replay;
`endif

    assign tick       = slow_clk & ~slow_prev_q;
    assign fb         = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-3] ^ lfsr_q[LFSR_W-4] ^ lfsr_q[LFSR_W-5];
    // An all-zero LFSR would never leave zero, so seed 0 is promoted to 1.
    assign seed_fixed = (seed == '0) ? LFSR_W'(1) : seed;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        len_d       = len_q;
        index_d     = index_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        slow_prev_d = slow_clk;
`ifdef SEQ_PLAYER_REPLAY_EN
        saved_seed_d = saved_seed_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_d  = seed_fixed;
                    len_d   = level;
                    index_d = '0;
                    busy_d  = 1'b1;
                    state_d = ARM;
`ifdef SEQ_PLAYER_REPLAY_EN
                    saved_seed_d = seed_fixed;
                end else if (replay) begin
                    lfsr_d  = (saved_seed_q == '0) ? LFSR_W'(1) : saved_seed_q;
                    index_d = '0;
                    busy_d  = 1'b1;
                    state_d = ARM;
`endif
                end
            end
            ARM: begin
                if (tick) state_d = SHOW;
            end
            SHOW: begin
                if (tick) state_d = GAP;
            end
            GAP: begin
                if (tick) begin
                    if (index_q == len_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        lfsr_d  = {lfsr_q[LFSR_W-2:0], fb};
                        index_d = index_q + LEN_W'(1);
                        state_d = SHOW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The LED follows the next LFSR value so a freshly stepped element shows immediately.
        led_d = (state_d == SHOW) ? (NUM_LED'(1) << lfsr_d[1:0]) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_W'(1);
            len_q       <= '0;
            index_q     <= '0;
            led_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            slow_prev_q <= 1'b0;
`ifdef SEQ_PLAYER_REPLAY_EN
            saved_seed_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            len_q       <= len_d;
            index_q     <= index_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            slow_prev_q <= slow_prev_d;
`ifdef SEQ_PLAYER_REPLAY_EN
            saved_seed_q <= saved_seed_d;
`endif
        end
    end

    assign led   = led_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign index = index_q;

endmodule
